// File: rtl/rst_ckpt_if.sv
// Dispatch, CDB, operand-read and recovery signals of the register status table.
// The master drives the table inputs; the slave (the table) drives its outputs.
interface rst_ckpt_if #(
   parameter int NUM_REGS  = 32,
   parameter int TAG_WIDTH = 6,
   localparam int AW       = $clog2(NUM_REGS)
);
   logic [TAG_WIDTH-1:0] dispatch_tag;
   logic                 dispatch_valid;
   logic [AW-1:0]        dispatch_addr;
   logic                 dispatch_wen;
   logic [TAG_WIDTH-1:0] cdb_tag;
   logic                 cdb_valid;
   logic [NUM_REGS-1:0]  regfile_wen_onehot;
   logic [AW-1:0]        dispatch_rsaddr;
   logic [TAG_WIDTH-1:0] dispatch_rstag;
   logic                 dispatch_rsvalid;
   logic [AW-1:0]        dispatch_rtaddr;
   logic [TAG_WIDTH-1:0] dispatch_rttag;
   logic                 dispatch_rtvalid;
   logic                 ckpt_save;
   logic                 ckpt_restore;
   logic                 flush;
   logic [AW:0]          busy_count;

   modport master (
      output dispatch_tag, dispatch_valid, dispatch_addr, dispatch_wen,
      output cdb_tag, cdb_valid, dispatch_rsaddr, dispatch_rtaddr,
      output ckpt_save, ckpt_restore, flush,
      input  regfile_wen_onehot, dispatch_rstag, dispatch_rsvalid,
      input  dispatch_rttag, dispatch_rtvalid, busy_count
   );

   modport slave (
      input  dispatch_tag, dispatch_valid, dispatch_addr, dispatch_wen,
      input  cdb_tag, cdb_valid, dispatch_rsaddr, dispatch_rtaddr,
      input  ckpt_save, ckpt_restore, flush,
      output regfile_wen_onehot, dispatch_rstag, dispatch_rsvalid,
      output dispatch_rttag, dispatch_rtvalid, busy_count
   );
endinterface

// File: rtl/rst_ckpt.sv
// Register status table for Tomasulo dispatch: pending flag and producer tag per
// architectural register, with CDB bypass, one-level checkpoint and flush.
module rst_ckpt #(
   parameter int NUM_REGS           = 32,
   parameter int TAG_WIDTH          = 6,
   parameter int ZERO_REG_HARDWIRED = 1,
   localparam int AW                = $clog2(NUM_REGS)
) (
   input logic       clk,
   input logic       reset_n,
   rst_ckpt_if.slave bus
);

   logic [NUM_REGS-1:0]  valid_q, valid_d;
   logic [NUM_REGS-1:0]  snap_valid_q, snap_valid_d;
   logic [NUM_REGS-1:0]  match, snap_match;
   logic [TAG_WIDTH-1:0] tag_q      [NUM_REGS];
   logic [TAG_WIDTH-1:0] tag_d      [NUM_REGS];
   logic [TAG_WIDTH-1:0] snap_tag_q [NUM_REGS];
   logic [TAG_WIDTH-1:0] snap_tag_d [NUM_REGS];
   logic [AW:0]          busy_q, busy_d;
   logic                 zero_hw;
   logic                 dispatch_do;

   assign zero_hw     = (ZERO_REG_HARDWIRED != 0);
   assign dispatch_do = bus.dispatch_valid & bus.dispatch_wen &
                        ~(zero_hw & (bus.dispatch_addr == '0));

   // The snapshot sees the same broadcast as the live table so a restore
   // never brings back a producer that has already completed.
   always_comb begin
      match      = '0;
      snap_match = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         match[i]      = bus.cdb_valid & valid_q[i]      & (tag_q[i]      == bus.cdb_tag);
         snap_match[i] = bus.cdb_valid & snap_valid_q[i] & (snap_tag_q[i] == bus.cdb_tag);
      end
   end

   always_comb begin
      valid_d      = valid_q & ~match;
      tag_d        = tag_q;
      snap_valid_d = snap_valid_q & ~snap_match;
      snap_tag_d   = snap_tag_q;
      if (bus.flush) begin
         valid_d = '0;
      end else if (bus.ckpt_restore) begin
         valid_d = snap_valid_q & ~snap_match;
         tag_d   = snap_tag_q;
      end else begin
         // Dispatch is applied after the clears so it wins a same-entry collision.
         if (dispatch_do) begin
            valid_d[bus.dispatch_addr] = 1'b1;
            tag_d[bus.dispatch_addr]   = bus.dispatch_tag;
         end
         if (bus.ckpt_save) begin
            snap_valid_d = valid_d;
            snap_tag_d   = tag_d;
         end
      end
   end

   always_comb begin
      busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_d = busy_d + {{AW{1'b0}}, valid_d[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q      <= '0;
         snap_valid_q <= '0;
         busy_q       <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            tag_q[i]      <= '0;
            snap_tag_q[i] <= '0;
         end
      end else begin
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         snap_valid_q <= snap_valid_d;
         snap_tag_q   <= snap_tag_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.regfile_wen_onehot = reset_n ? match : '0;
   assign bus.busy_count         = busy_q;

   assign bus.dispatch_rstag   = tag_q[bus.dispatch_rsaddr];
   assign bus.dispatch_rsvalid = valid_q[bus.dispatch_rsaddr] & ~match[bus.dispatch_rsaddr] &
                                 ~(zero_hw & (bus.dispatch_rsaddr == '0));
   assign bus.dispatch_rttag   = tag_q[bus.dispatch_rtaddr];
   assign bus.dispatch_rtvalid = valid_q[bus.dispatch_rtaddr] & ~match[bus.dispatch_rtaddr] &
                                 ~(zero_hw & (bus.dispatch_rtaddr == '0));

endmodule

// File: tb/tb_rst_ckpt.sv
// Scoreboard bench for rst_ckpt: directed scenarios plus randomized traffic
// checked against a table-level reference model.
module tb_rst_ckpt;

   typedef struct {
      logic       rstn;
      logic       dv;
      logic       dwen;
      logic [4:0] daddr;
      logic [5:0] dtag;
      logic       cv;
      logic [5:0] ctag;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       save;
      logic       restore;
      logic       flush;
   } stim_t;

   typedef struct {
      logic [31:0] wen;
      logic [5:0]  rstag;
      logic        rsv;
      logic [5:0]  rttag;
      logic        rtv;
      logic [5:0]  busy;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   bit   known  = 0;

   bit       mv [32];
   bit [5:0] mt [32];
   bit       sv [32];
   bit [5:0] st [32];

   exp_t sb[$];

   rst_ckpt_if #(.NUM_REGS(32), .TAG_WIDTH(6)) bus ();

   rst_ckpt #(.NUM_REGS(32), .TAG_WIDTH(6), .ZERO_REG_HARDWIRED(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle(input logic [4:0] rs, input logic [4:0] rt);
      stim_t s;
      s = '{rstn: 1'b1, dv: 1'b0, dwen: 1'b0, daddr: 5'd0, dtag: 6'd0, cv: 1'b0,
            ctag: 6'd0, rs: rs, rt: rt, save: 1'b0, restore: 1'b0, flush: 1'b0};
      return s;
   endfunction

   // Drives one cycle, records the expected response and advances the model.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      bit   hit [32];
      bit   shit [32];
      int   cnt;
      @(posedge clk);
      #1;
      reset_n            = s.rstn;
      bus.dispatch_valid = s.dv;
      bus.dispatch_wen   = s.dwen;
      bus.dispatch_addr  = s.daddr;
      bus.dispatch_tag   = s.dtag;
      bus.cdb_valid      = s.cv;
      bus.cdb_tag        = s.ctag;
      bus.dispatch_rsaddr = s.rs;
      bus.dispatch_rtaddr = s.rt;
      bus.ckpt_save      = s.save;
      bus.ckpt_restore   = s.restore;
      bus.flush          = s.flush;

      cnt   = 0;
      e.wen = '0;
      for (int i = 0; i < 32; i++) begin
         hit[i]  = s.cv && mv[i] && (mt[i] == s.ctag);
         shit[i] = s.cv && sv[i] && (st[i] == s.ctag);
         if (hit[i] && s.rstn) e.wen[i] = 1'b1;
         if (mv[i]) cnt++;
      end
      e.busy  = 6'(cnt);
      e.rstag = mt[s.rs];
      e.rttag = mt[s.rt];
      e.rsv   = (s.rs != 0) && mv[s.rs] && !hit[s.rs];
      e.rtv   = (s.rt != 0) && mv[s.rt] && !hit[s.rt];
      if (known) sb.push_back(e);

      if (!s.rstn) begin
         for (int i = 0; i < 32; i++) begin
            mv[i] = 0; mt[i] = '0; sv[i] = 0; st[i] = '0;
         end
         known = 1;
      end else if (s.flush) begin
         for (int i = 0; i < 32; i++) begin
            mv[i] = 0;
            if (shit[i]) sv[i] = 0;
         end
      end else if (s.restore) begin
         for (int i = 0; i < 32; i++) begin
            mv[i] = sv[i] && !shit[i];
            mt[i] = st[i];
            sv[i] = mv[i];
         end
      end else begin
         for (int i = 0; i < 32; i++) if (hit[i]) mv[i] = 0;
         if (s.dv && s.dwen && s.daddr != 0) begin
            mv[s.daddr] = 1;
            mt[s.daddr] = s.dtag;
         end
         for (int i = 0; i < 32; i++) begin
            if (s.save) begin
               sv[i] = mv[i]; st[i] = mt[i];
            end else if (shit[i]) begin
               sv[i] = 0;
            end
         end
      end
   endtask

   task automatic fillTable();
      stim_t s;
      for (int i = 1; i < 32; i++) begin
         s       = idle(5'd0, 5'd0);
         s.dv    = 1'b1;
         s.dwen  = 1'b1;
         s.daddr = 5'(i);
         s.dtag  = 6'(i);
         applyStimulus(s);
      end
   endtask

   task automatic resetCycles();
      stim_t s;
      s      = idle(5'd0, 5'd0);
      s.rstn = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
   endtask

   // Monitor: every cycle the table presents a fresh set of outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("sb_wen",     64'(bus.regfile_wen_onehot), 64'(e.wen));
            checkOutput("sb_rstag",   64'(bus.dispatch_rstag),     64'(e.rstag));
            checkOutput("sb_rsvalid", 64'(bus.dispatch_rsvalid),   64'(e.rsv));
            checkOutput("sb_rttag",   64'(bus.dispatch_rttag),     64'(e.rttag));
            checkOutput("sb_rtvalid", 64'(bus.dispatch_rtvalid),   64'(e.rtv));
            checkOutput("sb_busy",    64'(bus.busy_count),         64'(e.busy));
         end
      end
   end

   initial begin
      stim_t s;
      int    drain;
      int    pick;
      reset_n = 1'b0;
      bus.dispatch_valid = 0; bus.dispatch_wen = 0; bus.dispatch_addr = '0;
      bus.dispatch_tag = '0; bus.cdb_valid = 0; bus.cdb_tag = '0;
      bus.dispatch_rsaddr = '0; bus.dispatch_rtaddr = '0;
      bus.ckpt_save = 0; bus.ckpt_restore = 0; bus.flush = 0;

      resetCycles();
      applyStimulus(idle(5'd0, 5'd0));
      #1 checkOutput("reset_busy", 64'(bus.busy_count), 64'd0);

      fillTable();
      applyStimulus(idle(5'd5, 5'd0));
      #1;
      checkOutput("fill_rstag",   64'(bus.dispatch_rstag),   64'd5);
      checkOutput("fill_rsvalid", 64'(bus.dispatch_rsvalid), 64'd1);
      checkOutput("fill_zero",    64'(bus.dispatch_rtvalid), 64'd0);
      checkOutput("fill_busy",    64'(bus.busy_count),       64'd31);

      s = idle(5'd7, 5'd7); s.cv = 1'b1; s.ctag = 6'd7;
      applyStimulus(s);
      #1;
      checkOutput("bypass_rsvalid", 64'(bus.dispatch_rsvalid),   64'd0);
      checkOutput("bypass_wen",     64'(bus.regfile_wen_onehot), 64'h80);
      applyStimulus(idle(5'd7, 5'd8));
      #1;
      checkOutput("clear_rsvalid", 64'(bus.dispatch_rsvalid), 64'd0);
      checkOutput("clear_busy",    64'(bus.busy_count),       64'd30);

      resetCycles();
      fillTable();
      s = idle(5'd0, 5'd0); s.save = 1'b1;
      applyStimulus(s);
      s = idle(5'd0, 5'd0); s.dv = 1'b1; s.dwen = 1'b1; s.daddr = 5'd9; s.dtag = 6'd40;
      applyStimulus(s);
      s = idle(5'd0, 5'd0); s.cv = 1'b1; s.ctag = 6'd2;
      applyStimulus(s);
      s = idle(5'd0, 5'd0); s.restore = 1'b1;
      applyStimulus(s);
      applyStimulus(idle(5'd9, 5'd2));
      #1;
      checkOutput("ckpt_tag9",   64'(bus.dispatch_rstag),   64'd9);
      checkOutput("ckpt_valid9", 64'(bus.dispatch_rsvalid), 64'd1);
      checkOutput("ckpt_valid2", 64'(bus.dispatch_rtvalid), 64'd0);
      checkOutput("ckpt_busy",   64'(bus.busy_count),       64'd30);

      s = idle(5'd0, 5'd0); s.dv = 1'b1; s.dwen = 1'b1; s.daddr = 5'd3; s.dtag = 6'd12;
      s.cv = 1'b1; s.ctag = 6'd3;
      applyStimulus(s);
      #1 checkOutput("collide_wen", 64'(bus.regfile_wen_onehot), 64'h8);
      applyStimulus(idle(5'd3, 5'd0));
      #1;
      checkOutput("collide_tag",   64'(bus.dispatch_rstag),   64'd12);
      checkOutput("collide_valid", 64'(bus.dispatch_rsvalid), 64'd1);

      s = idle(5'd0, 5'd0); s.flush = 1'b1; s.dv = 1'b1; s.dwen = 1'b1;
      s.daddr = 5'd4; s.dtag = 6'd50;
      applyStimulus(s);
      applyStimulus(idle(5'd4, 5'd9));
      #1;
      checkOutput("flush_busy",  64'(bus.busy_count),         64'd0);
      checkOutput("flush_valid", 64'(bus.dispatch_rsvalid),   64'd0);
      checkOutput("flush_wen",   64'(bus.regfile_wen_onehot), 64'd0);

      fillTable();
      s = idle(5'd5, 5'd0); s.save = 1'b1;
      applyStimulus(s);
      s = idle(5'd5, 5'd0); s.rstn = 1'b0; s.dv = 1'b1; s.dwen = 1'b1;
      s.daddr = 5'd6; s.dtag = 6'd33; s.cv = 1'b1; s.ctag = 6'd5;
      applyStimulus(s);
      #1 checkOutput("rst_wen", 64'(bus.regfile_wen_onehot), 64'd0);
      applyStimulus(idle(5'd5, 5'd6));
      #1;
      checkOutput("rst_busy",  64'(bus.busy_count),       64'd0);
      checkOutput("rst_tag",   64'(bus.dispatch_rstag),   64'd0);
      checkOutput("rst_valid", 64'(bus.dispatch_rsvalid), 64'd0);
      s = idle(5'd5, 5'd6); s.restore = 1'b1;
      applyStimulus(s);
      applyStimulus(idle(5'd5, 5'd6));
      #1;
      checkOutput("restore_busy",  64'(bus.busy_count),       64'd0);
      checkOutput("restore_valid", 64'(bus.dispatch_rsvalid), 64'd0);

      for (int n = 0; n < 600; n++) begin
         s = idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         s.dv    = ($urandom_range(0, 9) < 7);
         s.dwen  = ($urandom_range(0, 9) < 8);
         s.daddr = 5'($urandom_range(0, 31));
         s.dtag  = 6'($urandom_range(0, 15));
         s.cv    = ($urandom_range(0, 9) < 6);
         pick    = $urandom_range(0, 31);
         s.ctag  = ($urandom_range(0, 1) == 1) ? mt[pick] : 6'($urandom_range(0, 15));
         s.save    = ($urandom_range(0, 99) < 6);
         s.restore = ($urandom_range(0, 99) < 5);
         s.flush   = ($urandom_range(0, 99) < 3);
         if (s.flush) s.cv = 1'b0;
         s.rstn  = ($urandom_range(0, 99) != 0);
         applyStimulus(s);
      end
      applyStimulus(idle(5'd0, 5'd0));

      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
